// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcodes, FSM states and
// the combinational ALU function used by the single shared ALU.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_RSV3 = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Reserved codes (011, 111) fall through to zero, so they report Zero=1.
  // SLT is an unsigned compare; add/sub/mul keep the low 32 bits only.
  function automatic logic [31:0] alu_eval(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [2:0]  ctrl);
    logic [31:0] r;
    r = '0;
    case (ctrl)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_MUL: r = a * b;
      ALU_SLT: r = {31'd0, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter: one-hot grant to the first requester after ptr,
// wrapping modulo NREQ, plus the encoded index of that grant.
module rr_arbiter_onehot #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  // Circular search starting just after the last winner; first hit wins.
  always_comb begin
    logic [IDW-1:0] k;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = '0;
    if (en) begin
      for (int i = 1; i <= NREQ; i++) begin
        k = IDW'((int'(ptr) + i) % NREQ);
        if (!gnt_any && req[k]) begin
          gnt_any = 1'b1;
          gnt[k]  = 1'b1;
          gnt_idx = k;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// One 32-bit ALU shared between NREQ requesters with round-robin grant,
// registered operands/results and a multi-cycle slot for multiply.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no transaction; arbiter enabled, grant latches operands
//   ST_EXEC | ALU driven from latched operands; counts down MUL cycles
//   ST_RESP | result held on Rsp_*, waiting for Rsp_Ready
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int IDW        = 1,
  parameter int MUL_CYCLES = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    Req_Valid,
  output logic [NREQ-1:0]    Req_Ready,
  input  logic [NREQ*32-1:0] Req_SrcA,
  input  logic [NREQ*32-1:0] Req_SrcB,
  input  logic [NREQ*3-1:0]  Req_Ctrl,
  output logic               Rsp_Valid,
  input  logic               Rsp_Ready,
  output logic [IDW-1:0]     Rsp_Id,
  output logic [31:0]        Rsp_Result,
  output logic               Rsp_Zero,
  output logic               Busy
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_e         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic [NREQ-1:0] gnt;
  logic           gnt_any;
  logic           arb_en;
  logic [CW-1:0]  exec_cnt;
  logic [31:0]    op_a, op_b;
  logic [2:0]     op_ctrl;
  logic [IDW-1:0] op_id;
  logic [31:0]    alu_result;
  logic           alu_zero;

  logic [31:0] src_a [NREQ];
  logic [31:0] src_b [NREQ];
  logic [2:0]  ctrl  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign src_a[gi] = Req_SrcA[gi*32 +: 32];
    assign src_b[gi] = Req_SrcB[gi*32 +: 32];
    assign ctrl[gi]  = Req_Ctrl[gi*3 +: 3];
  end

  rr_arbiter_onehot #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (Req_Valid),
    .ptr     (rr_ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // The shared ALU only ever sees the latched operands.
  assign alu_result = alu_eval(op_a, op_b, op_ctrl);
  assign alu_zero   = (alu_result == 32'd0);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (gnt_any) state_nxt = ST_EXEC;
      ST_EXEC: if (exec_cnt == '0) state_nxt = ST_RESP;
      ST_RESP: if (Rsp_Ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-derived outputs; arbitration is suppressed while reset is asserted.
  always_comb begin
    arb_en    = (state == ST_IDLE) && !RST;
    Req_Ready = gnt;
    Rsp_Valid = (state == ST_RESP);
    Busy      = (state != ST_IDLE);
  end

  // Grant capture: operands, owner id, pointer and exec counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr   <= IDW'(NREQ - 1);
      op_a     <= '0;
      op_b     <= '0;
      op_ctrl  <= '0;
      op_id    <= '0;
      exec_cnt <= '0;
    end else if (gnt_any) begin
      rr_ptr   <= gnt_idx;
      op_a     <= src_a[gnt_idx];
      op_b     <= src_b[gnt_idx];
      op_ctrl  <= ctrl[gnt_idx];
      op_id    <= gnt_idx;
      exec_cnt <= (ctrl[gnt_idx] == ALU_MUL) ? CW'(MUL_CYCLES - 1) : '0;
    end else if (state == ST_EXEC && exec_cnt != '0) begin
      exec_cnt <= exec_cnt - CW'(1);
    end
  end

  // Response registers load on the last EXEC cycle and hold through RESP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Rsp_Result <= '0;
      Rsp_Zero   <= 1'b0;
      Rsp_Id     <= '0;
    end else if (state == ST_EXEC && exec_cnt == '0) begin
      Rsp_Result <= alu_result;
      Rsp_Zero   <= alu_zero;
      Rsp_Id     <= op_id;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (NREQ=2, MUL_CYCLES=3).
module tb_alu_share_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  Req_Valid;
  logic [1:0]  Req_Ready;
  logic [63:0] Req_SrcA;
  logic [63:0] Req_SrcB;
  logic [5:0]  Req_Ctrl;
  logic        Rsp_Valid;
  logic        Rsp_Ready;
  logic [0:0]  Rsp_Id;
  logic [31:0] Rsp_Result;
  logic        Rsp_Zero;
  logic        Busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];

  alu_share_arbiter #(.NREQ(2), .IDW(1), .MUL_CYCLES(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Req_Valid  (Req_Valid),
    .Req_Ready  (Req_Ready),
    .Req_SrcA   (Req_SrcA),
    .Req_SrcB   (Req_SrcB),
    .Req_Ctrl   (Req_Ctrl),
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_Ready  (Rsp_Ready),
    .Rsp_Id     (Rsp_Id),
    .Rsp_Result (Rsp_Result),
    .Rsp_Zero   (Rsp_Zero),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      3'b110:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard monitor: push on accept, pop and compare on response handshake.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      sb.delete();
    end else begin
      if (Rsp_Valid && Rsp_Ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got id=%0d res=%0d with nothing expected",
                   Rsp_Id, Rsp_Result);
        end else begin
          e = sb.pop_front();
          if ({Rsp_Id, Rsp_Result, Rsp_Zero} !== {e.id, e.res, e.zero}) begin
            n_fail++;
            $display("FAIL rsp_data: got id=%0d res=%0d zero=%0d expected id=%0d res=%0d zero=%0d",
                     Rsp_Id, Rsp_Result, Rsp_Zero, e.id, e.res, e.zero);
          end
        end
      end
      if (Req_Ready != 2'b00) begin
        n_tests++;
        if ($countones(Req_Ready) != 1) begin
          n_fail++;
          $display("FAIL ready_onehot: got %b expected one-hot", Req_Ready);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (Req_Ready[i]) begin
          e.id   = 1'(i);
          e.res  = model(Req_SrcA[i*32 +: 32], Req_SrcB[i*32 +: 32], Req_Ctrl[i*3 +: 3]);
          e.zero = (e.res == 32'd0);
          sb.push_back(e);
          gnt_log.push_back(i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c);
    Req_SrcA[i*32 +: 32] = a;
    Req_SrcB[i*32 +: 32] = b;
    Req_Ctrl[i*3 +: 3]   = c;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    Req_Valid = 2'b11;
    Rsp_Ready = 1'b0;
    set_req(0, 32'd1, 32'd1, 3'b010);
    set_req(1, 32'd2, 32'd2, 3'b010);
    step;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_tests++;
      if (Req_Ready !== 2'b00 || Rsp_Valid !== 1'b0 || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got ready=%b rsp_valid=%b busy=%b expected 00/0/0",
                 Req_Ready, Rsp_Valid, Busy);
      end
      step;
    end
    @(negedge CLK);
    n_tests++;
    if (Rsp_Id !== 1'b0 || Rsp_Result !== 32'd0 || Rsp_Zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: got id=%0d res=%0d zero=%0d expected 0/0/0",
               Rsp_Id, Rsp_Result, Rsp_Zero);
    end
    step;
    RST = 1'b0;
    Req_Valid = 2'b00;
  endtask

  task automatic test_single_add;
    int lat;
    set_req(0, 32'd5, 32'd7, 3'b010);
    Rsp_Ready = 1'b1;
    Req_Valid = 2'b01;
    @(negedge CLK);
    n_tests++;
    if (Req_Ready !== 2'b01) begin
      n_fail++;
      $display("FAIL add_grant: got %b expected 01", Req_Ready);
    end
    lat = 0;
    do begin
      step;
      Req_Valid = 2'b00;
      @(negedge CLK);
      lat++;
    end while (!Rsp_Valid && lat < 20);
    n_tests++;
    if (lat - 1 !== 1) begin
      n_fail++;
      $display("FAIL add_latency: got %0d expected 1", lat - 1);
    end
    n_tests++;
    if (Rsp_Result !== 32'd12 || Rsp_Zero !== 1'b0 || Rsp_Id !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: got res=%0d zero=%0d id=%0d expected 12/0/0",
               Rsp_Result, Rsp_Zero, Rsp_Id);
    end
    step;
    @(negedge CLK);
    n_tests++;
    if (Busy !== 1'b0 || Rsp_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_idle: got busy=%b rsp_valid=%b expected 0/0", Busy, Rsp_Valid);
    end
    step;
  endtask

  task automatic test_mul;
    int lat;
    set_req(1, 32'd6, 32'd7, 3'b101);
    Rsp_Ready = 1'b1;
    Req_Valid = 2'b10;
    @(negedge CLK);
    n_tests++;
    if (Req_Ready !== 2'b10) begin
      n_fail++;
      $display("FAIL mul_grant: got %b expected 10", Req_Ready);
    end
    lat = 0;
    do begin
      step;
      Req_Valid = 2'b00;
      @(negedge CLK);
      lat++;
    end while (!Rsp_Valid && lat < 20);
    n_tests++;
    if (lat - 1 !== 3) begin
      n_fail++;
      $display("FAIL mul_latency: got %0d expected 3", lat - 1);
    end
    n_tests++;
    if (Rsp_Result !== 32'd42 || Rsp_Id !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_result: got res=%0d id=%0d expected 42/1", Rsp_Result, Rsp_Id);
    end
    step;
    step;
  endtask

  task automatic test_contention;
    int cyc;
    int exp_order[4] = '{0, 1, 0, 1};
    set_req(0, 32'd9, 32'd9, 3'b100);
    set_req(1, 32'd9, 32'd9, 3'b100);
    Rsp_Ready = 1'b1;
    gnt_log.delete();
    Req_Valid = 2'b11;
    cyc = 0;
    while (gnt_log.size() < 4 && cyc < 40) begin
      step;
      cyc++;
    end
    Req_Valid = 2'b00;
    n_tests++;
    if (gnt_log.size() < 4) begin
      n_fail++;
      $display("FAIL cont_timeout: got %0d grants expected 4", gnt_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (gnt_log[i] !== exp_order[i]) begin
          n_fail++;
          $display("FAIL cont_order[%0d]: got %0d expected %0d", i, gnt_log[i], exp_order[i]);
        end
      end
    end
    cyc = 0;
    @(negedge CLK);
    while (Busy && cyc < 20) begin
      step;
      @(negedge CLK);
      cyc++;
    end
    n_tests++;
    if (Busy !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL cont_drain: got busy=%b pending=%0d expected 0/0", Busy, sb.size());
    end
    step;
  endtask

  task automatic test_backpressure;
    int lat;
    set_req(0, 32'd100, 32'd23, 3'b010);
    set_req(1, 32'd1, 32'd1, 3'b001);
    Rsp_Ready = 1'b0;
    Req_Valid = 2'b01;
    @(negedge CLK);
    n_tests++;
    if (Req_Ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_grant: got %b expected 01", Req_Ready);
    end
    lat = 0;
    do begin
      step;
      Req_Valid = 2'b00;
      @(negedge CLK);
      lat++;
    end while (!Rsp_Valid && lat < 20);
    step;
    Req_Valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      n_tests++;
      if (Rsp_Valid !== 1'b1 || Rsp_Result !== 32'd123 || Rsp_Zero !== 1'b0 ||
          Rsp_Id !== 1'b0 || Req_Ready !== 2'b00 || Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b res=%0d z=%b id=%0d rdy=%b busy=%b expected 1/123/0/0/00/1",
                 c, Rsp_Valid, Rsp_Result, Rsp_Zero, Rsp_Id, Req_Ready, Busy);
      end
      step;
    end
    Req_Valid = 2'b00;
    Rsp_Ready = 1'b1;
    step;
    @(negedge CLK);
    n_tests++;
    if (Rsp_Valid !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got rsp_valid=%b busy=%b expected 0/0", Rsp_Valid, Busy);
    end
    step;
  endtask

  task automatic test_reset_exec;
    int lat;
    set_req(0, 32'd3, 32'd4, 3'b101);
    Rsp_Ready = 1'b1;
    Req_Valid = 2'b01;
    @(negedge CLK);
    step;
    Req_Valid = 2'b00;
    RST = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_exec: got busy=%b expected 1", Busy);
    end
    step;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_tests++;
      if (Rsp_Valid !== 1'b0 || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rx_in_reset: got rsp_valid=%b busy=%b expected 0/0", Rsp_Valid, Busy);
      end
      step;
    end
    RST = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      n_tests++;
      if (Rsp_Valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rx_no_rsp: got rsp_valid=%b expected 0", Rsp_Valid);
      end
      step;
    end
    set_req(0, 32'd1, 32'd2, 3'b110);
    set_req(1, 32'd9, 32'd9, 3'b010);
    Req_Valid = 2'b11;
    @(negedge CLK);
    n_tests++;
    if (Req_Ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rx_ptr_grant: got %b expected 01", Req_Ready);
    end
    lat = 0;
    do begin
      step;
      Req_Valid = 2'b00;
      @(negedge CLK);
      lat++;
    end while (!Rsp_Valid && lat < 20);
    n_tests++;
    if (Rsp_Valid !== 1'b1 || Rsp_Result !== 32'd1 || Rsp_Id !== 1'b0 || Rsp_Zero !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_slt: got v=%b res=%0d id=%0d zero=%b expected 1/1/0/0",
               Rsp_Valid, Rsp_Result, Rsp_Id, Rsp_Zero);
    end
    step;
    step;
  endtask

  initial begin
    RST       = 1'b1;
    Req_Valid = 2'b00;
    Req_SrcA  = '0;
    Req_SrcB  = '0;
    Req_Ctrl  = '0;
    Rsp_Ready = 1'b0;
    test_reset;
    test_single_add;
    test_mul;
    test_contention;
    test_backpressure;
    test_reset_exec;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
